// File: rtl/radar_mode_ctrl.sv
// radar_mode_ctrl: radar mode sequencer (scan/lock/wait-clear/manual) with a debounced manual button,
// lock-angle capture and a saturating detection counter.
module radar_mode_ctrl #(
    parameter int THRESH_CM       = 30,
    parameter int HYST_CM         = 5,
    parameter int CONFIRM_N       = 3,
    parameter int CLEAR_N         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LOCK_TIMEOUT    = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       manual_btn,
    input  logic       dist_valid,
    input  logic [8:0] dist_cm,
    input  logic [7:0] servo_angle,
    output logic [1:0] state,
    output logic       alert_active,
    output logic [7:0] lock_angle,
    output logic [7:0] target_count
);
    typedef enum logic [1:0] {SCAN, LOCK, WAIT_CLEAR, MANUAL} state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [9:0] NEAR_LIM = 10'(THRESH_CM);
    localparam logic [9:0] CLR_LIM  = 10'(THRESH_CM + HYST_CM);
    localparam logic [3:0] CONF_N   = 4'(CONFIRM_N);
    localparam logic [3:0] CLR_N    = 4'(CLEAR_N);

    logic          sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, press_q, press_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    state_t        state_q, state_d;
    logic          alert_q, alert_d;
    logic [7:0]    lock_angle_q, lock_angle_d, target_count_q, target_count_d;
    logic [3:0]    conf_q, conf_d, clr_q, clr_d, conf_inc, clr_inc;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          near, clr, enter_lock;

    // The debounced level only flips after DEBOUNCE_CYCLES unbroken cycles of disagreement
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
            else deb_cnt_d = deb_cnt_q + 1'b1;
        end
        press_d = deb_q & ~deb_prev_q;
    end

    assign near     = dist_valid && ({1'b0, dist_cm} < NEAR_LIM);
    assign clr      = dist_valid && ({1'b0, dist_cm} >= CLR_LIM);
    assign conf_inc = (conf_q == CONF_N) ? conf_q : conf_q + 1'b1;
    assign clr_inc  = (&clr_q) ? clr_q : clr_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        lock_angle_d   = lock_angle_q;
        target_count_d = target_count_q;
        conf_d         = near ? conf_inc : dist_valid ? 4'd0 : conf_q;
        clr_d          = near ? 4'd0 : clr ? clr_inc : clr_q;
        tmr_d          = (dist_valid || state_q != LOCK) ? '0 : tmr_q + 1'b1;
        enter_lock     = 1'b0;
        if (press_q) begin
            state_d = (state_q == MANUAL) ? SCAN : MANUAL;
            conf_d  = '0;
            clr_d   = '0;
        end else begin
            case (state_q)
                SCAN: enter_lock = near && (conf_inc == CONF_N);
                LOCK: begin
                    if (clr) begin
                        state_d = WAIT_CLEAR;
                        clr_d   = 4'd1;
                    end else if (!dist_valid && tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
                        state_d = WAIT_CLEAR;
                        clr_d   = '0;
                    end
                end
                WAIT_CLEAR: begin
                    if (near) enter_lock = 1'b1;
                    else if (clr && clr_inc == CLR_N) begin
                        state_d = SCAN;
                        conf_d  = '0;
                        clr_d   = '0;
                    end
                end
                default: begin
                    conf_d = '0;
                    clr_d  = '0;
                end
            endcase
        end
        if (enter_lock) begin
            state_d        = LOCK;
            lock_angle_d   = servo_angle;
            target_count_d = (&target_count_q) ? target_count_q : target_count_q + 1'b1;
            conf_d         = '0;
            clr_d          = '0;
            tmr_d          = '0;
        end
        alert_d = (state_d == LOCK) || (state_d == WAIT_CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_q          <= 1'b0;
            deb_prev_q     <= 1'b0;
            press_q        <= 1'b0;
            deb_cnt_q      <= '0;
            state_q        <= SCAN;
            alert_q        <= 1'b0;
            lock_angle_q   <= '0;
            target_count_q <= '0;
            conf_q         <= '0;
            clr_q          <= '0;
            tmr_q          <= '0;
        end else begin
            sync1_q        <= manual_btn;
            sync2_q        <= sync1_q;
            deb_q          <= deb_d;
            deb_prev_q     <= deb_q;
            press_q        <= press_d;
            deb_cnt_q      <= deb_cnt_d;
            state_q        <= state_d;
            alert_q        <= alert_d;
            lock_angle_q   <= lock_angle_d;
            target_count_q <= target_count_d;
            conf_q         <= conf_d;
            clr_q          <= clr_d;
            tmr_q          <= tmr_d;
        end
    end

    assign state        = state_q;
    assign alert_active = alert_q;
    assign lock_angle   = lock_angle_q;
    assign target_count = target_count_q;
endmodule

// File: tb/tb_radar_mode_ctrl.sv
// tb_radar_mode_ctrl: table-driven sample vectors with a scoreboard queue, plus hand-written
// timeout, button and reset sequences.
module tb_radar_mode_ctrl;
    logic       clk = 1'b0, reset_n = 1'b0, manual_btn = 1'b0, dist_valid = 1'b0;
    logic [8:0] dist_cm = '0;
    logic [7:0] servo_angle = '0;
    logic [1:0] state;
    logic       alert_active;
    logic [7:0] lock_angle, target_count;

    radar_mode_ctrl #(.DEBOUNCE_CYCLES(4), .LOCK_TIMEOUT(100)) dut (
        .clk(clk), .reset_n(reset_n), .manual_btn(manual_btn), .dist_valid(dist_valid),
        .dist_cm(dist_cm), .servo_angle(servo_angle), .state(state),
        .alert_active(alert_active), .lock_angle(lock_angle), .target_count(target_count));

    always #5 clk = ~clk;

    typedef struct {logic [8:0] d; logic [7:0] a; logic [1:0] st; logic [7:0] la; logic [7:0] tc;} vec_t;
    typedef struct {logic [1:0] st; logic [7:0] la; logic [7:0] tc;} exp_t;
    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;

    localparam logic [1:0] S = 2'd0, L = 2'd1, W = 2'd2, M = 2'd3;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic add(input int d, input int a, input logic [1:0] st, input int la, input int tc);
        tbl.push_back('{9'(d), 8'(a), st, 8'(la), 8'(tc)});
    endtask

    task automatic apply(input string nm, input int d, input int a, input logic [1:0] st, input int la, input int tc);
        exp_t e;
        @(negedge clk);
        dist_valid  = 1'b1;
        dist_cm     = 9'(d);
        servo_angle = 8'(a);
        sb.push_back('{st, 8'(la), 8'(tc)});
        @(posedge clk);
        #1;
        dist_valid = 1'b0;
        e = sb.pop_front();
        chk({nm, ".state"}, int'(state), int'(e.st));
        chk({nm, ".alert"}, int'(alert_active), int'(e.st == L || e.st == W));
        chk({nm, ".lock_angle"}, int'(lock_angle), int'(e.la));
        chk({nm, ".target_count"}, int'(target_count), int'(e.tc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, tc_exp, a;
        #12;
        chk("reset.state", int'(state), 0);
        chk("reset.alert", int'(alert_active), 0);
        chk("reset.lock_angle", int'(lock_angle), 0);
        chk("reset.target_count", int'(target_count), 0);
        @(negedge clk) reset_n = 1'b1;

        add(20, 90, S, 0, 0);  add(20, 90, S, 0, 0);  add(20, 90, L, 90, 1);
        add(40, 50, W, 90, 1); add(40, 50, W, 90, 1); add(40, 50, W, 90, 1);
        add(40, 50, W, 90, 1); add(40, 50, S, 90, 1);
        add(20, 10, S, 90, 1); add(20, 10, S, 90, 1); add(32, 10, S, 90, 1);
        add(20, 10, S, 90, 1); add(20, 10, S, 90, 1); add(20, 77, L, 77, 2);
        add(40, 0, W, 77, 2);  add(40, 0, W, 77, 2);  add(10, 120, L, 120, 3);
        add(40, 0, W, 120, 3); add(40, 0, W, 120, 3); add(40, 0, W, 120, 3);
        add(40, 0, W, 120, 3); add(40, 0, S, 120, 3);
        add(20, 30, S, 120, 3); add(20, 30, S, 120, 3); add(20, 30, L, 30, 4);
        add(32, 0, L, 30, 4);  add(25, 0, L, 30, 4);
        add(40, 0, W, 30, 4);  add(32, 0, W, 30, 4);  add(40, 0, W, 30, 4);
        add(40, 0, W, 30, 4);  add(40, 0, W, 30, 4);  add(40, 0, S, 30, 4);
        add(20, 60, S, 30, 4); add(20, 60, S, 30, 4); add(20, 60, L, 60, 5);
        add(34, 0, L, 60, 5);  add(35, 0, W, 60, 5);  add(29, 61, L, 61, 6);
        add(30, 0, L, 61, 6);
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i].d, tbl[i].a, tbl[i].st, tbl[i].la, tbl[i].tc);

        repeat (99) @(posedge clk);
        #1 chk("timeout.cycle99", int'(state), int'(L));
        @(posedge clk);
        #1 chk("timeout.cycle100", int'(state), int'(W));
        chk("timeout.alert", int'(alert_active), 1);

        apply("relock", 20, 45, L, 45, 7);
        repeat (98) @(posedge clk);
        @(negedge clk);
        dist_valid = 1'b1;
        dist_cm    = 9'd20;
        @(posedge clk);
        #1 dist_valid = 1'b0;
        chk("reload.cycle99", int'(state), int'(L));
        @(posedge clk);
        #1 chk("reload.cycle100", int'(state), int'(L));

        apply("back_w", 40, 0, W, 45, 7);
        for (int i = 0; i < 3; i++) apply("back_w", 40, 0, W, 45, 7);
        apply("back_s", 40, 0, S, 45, 7);
        apply("pre_near", 20, 0, S, 45, 7);
        apply("pre_near", 20, 0, S, 45, 7);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            manual_btn = 1'b1;
            @(negedge clk);
            @(negedge clk);
            manual_btn = 1'b0;
            @(negedge clk);
        end
        @(negedge clk) manual_btn = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("press.not_early", int'(state), int'(S));
        dist_valid = 1'b1;
        dist_cm    = 9'd20;
        @(posedge clk);
        #1 dist_valid = 1'b0;
        chk("press.manual_wins", int'(state), int'(M));
        chk("press.alert", int'(alert_active), 0);
        chk("press.target_count", int'(target_count), 7);

        for (int i = 0; i < 3; i++) apply("manual_ignore", 20, 5, M, 45, 7);
        @(negedge clk) manual_btn = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("release.no_press", int'(state), int'(M));

        @(negedge clk) manual_btn = 1'b1;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (state == S) begin
                lat = i;
                break;
            end
        end
        chk("press2.latency", lat, 8);
        apply("post_manual", 20, 100, S, 45, 7);
        apply("post_manual", 20, 100, S, 45, 7);
        apply("post_manual", 20, 100, L, 100, 8);
        @(negedge clk) manual_btn = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("release2.hold", int'(state), int'(L));

        tc_exp = 8;
        for (int i = 0; i < 256; i++) begin
            a = i % 181;
            apply("sat_w", 40, 0, W, (i == 0) ? 100 : ((i - 1) % 181), tc_exp);
            tc_exp = (tc_exp == 255) ? 255 : tc_exp + 1;
            apply("sat_l", 20, a, L, a, tc_exp);
        end
        chk("sat.final", int'(target_count), 255);
        apply("pre_reset", 40, 0, W, 255 % 181, 255);

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset.state", int'(state), 0);
        chk("midreset.alert", int'(alert_active), 0);
        chk("midreset.lock_angle", int'(lock_angle), 0);
        chk("midreset.target_count", int'(target_count), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 chk("after_reset.state", int'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
